ir_seg_sequencer: RTL and testbench
===================================

// Module: ir_seg_sequencer
// PURPOSE
//  Avalon-MM master that shows decoded IR remote codes on the two duo 7-segment
//  slaves (left = command byte, right = address byte). Sits between the infrared
//  receiver's decoded-code output and the s1/s2 duo-seg slave ports.
//  Sequences the write transactions, holds one pending code, and blanks both
//  displays after a hold timeout.
// PARAMETERS
//  HOLD_CYCLES  50_000_000    cycles a code stays displayed (1 s @ 50 MHz); >=1
//  REPEAT_CODE  32'hFFFF_FFFF code treated as key-repeat (restarts hold, no writes)
// PORTS
//  csi_clk        in   1   clock
//  csi_reset      in   1   synchronous active-high reset
//  ir_valid       in   1   one-cycle pulse, ir_code valid
//  ir_code        in   32  decoded code: [23:16] command, [7:0] address
//  m1_address     out  2   left duo-seg slave address (always 2'd0)
//  m1_write       out  1   left write request
//  m1_writedata   out  16  left write data
//  m1_byteenable  out  2   left byte enables (always 2'b11)
//  m1_waitrequest in   1   left slave stall
//  m2_*           -    -   same five signals for the right duo-seg slave
//  busy           out  1   1 in any WR_*/BLANK_* state
//  overrun_cnt    out  8   pending-slot overwrites, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE, m*_write=0, m*_address=0, m*_writedata=0,
//   m*_byteenable=2'b11, busy=0, overrun_cnt=0, pending empty, hold timer 0.
//  Slave data word: [7:0] two hex digits, [8] blank (1 = both digits dark),
//   [15:9]=0. Show word = {7'b0,1'b0,byte}; blank word = 16'h0100.
//  Master rule: address/data/write held stable while m*_waitrequest=1;
//   transfer completes on the edge where write=1 and waitrequest=0;
//   write drops the following cycle unless the next state writes the same port.
//   Only one port is written at a time.
//  States: IDLE, WR_L, WR_R, HOLD, BLANK_L, BLANK_R.
//   IDLE/HOLD + ir_valid (code!=REPEAT_CODE): latch code; next cycle WR_L,
//    m1_write=1, m1_writedata=show(code[23:16]).
//   WR_L complete -> WR_R, m2_write=1, m2_writedata=show(code[7:0]).
//   WR_R complete -> pending ? WR_L with pending code (slot cleared)
//    : HOLD with timer=HOLD_CYCLES-1.
//   HOLD: timer decrements each cycle; at 0 with no accept -> BLANK_L.
//   BLANK_L: m1 writes 16'h0100; complete -> BLANK_R: m2 writes 16'h0100.
//   BLANK_R complete -> pending ? WR_L with pending code : IDLE.
//  Repeat code: in HOLD reloads timer to HOLD_CYCLES-1; ignored in all other
//   states (never stored as pending).
//  ir_valid (non-repeat) during WR_*/BLANK_*: stored in pending slot; if slot
//   already full it is overwritten by the newer code and overrun_cnt += 1 (sat).
//  Same-edge events: ir_valid on the completing edge of WR_R/BLANK_R goes into
//   the pending slot first, so the newest code is the one displayed next.
//   ir_valid in HOLD on the cycle the timer hits 0: accept wins, no blanking.
//  Latency: ir_valid in IDLE -> m1_write high 1 cycle later; zero-wait slaves
//   give code on both displays 2 cycles after m1_write rises.
//  Reset mid-transfer: write drops at the next edge; no completion is implied.
// TESTING
//  1 Reset, ir_valid code 32'h00FF_1A2B, no waits -> m1 writes 16'h00FF then m2
//    writes 16'h002B on consecutive cycles; busy=1 for exactly 2 cycles.
//  2 m1_waitrequest=1 for 5 cycles -> m1 addr/data stable for 6 cycles, then one
//    m2 write; no m2_write while m1_write=1.
//  3 HOLD_CYCLES=10, single code -> 10 cycles in HOLD, then m1 and m2 write 16'h0100,
//    state IDLE; a REPEAT_CODE at HOLD cycle 8 delays blanking by 9 cycles.
//  4 Three codes during WR_L stall -> only the third is displayed after the first;
//    overrun_cnt=1.
//  5 Code on the WR_R completing edge -> displayed immediately after, no HOLD visit.
//  6 Assert csi_reset while m2_write=1 under waitrequest -> next cycle all outputs
//    at reset values; overrun_cnt=0; the next code starts a fresh WR_L.

Source files
------------

// File: rtl/ir_seg_sequencer.sv
// Avalon-MM master that writes decoded IR codes to two duo 7-segment slaves
// (left = command byte, right = address byte) and blanks them after a hold timeout.
module ir_seg_sequencer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter logic [31:0] REPEAT_CODE = 32'hFFFF_FFFF
) (
  input  logic        csi_clk,
  input  logic        csi_reset,
  input  logic        ir_valid,
  input  logic [31:0] ir_code,
  output logic [1:0]  m1_address,
  output logic        m1_write,
  output logic [15:0] m1_writedata,
  output logic [1:0]  m1_byteenable,
  input  logic        m1_waitrequest,
  output logic [1:0]  m2_address,
  output logic        m2_write,
  output logic [15:0] m2_writedata,
  output logic [1:0]  m2_byteenable,
  input  logic        m2_waitrequest,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned TimerW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerReload = TimerW'(HOLD_CYCLES - 1);
  localparam logic [15:0] BlankWord = 16'h0100;

  typedef enum logic [2:0] {
    StIdle,
    StWrL,
    StWrR,
    StHold,
    StBlankL,
    StBlankR
  } state_e;

  state_e            state;
  logic [TimerW-1:0] timer;
  logic [7:0]        cur_addr;
  logic              pend_valid;
  logic [31:0]       pend_code;

  logic        is_repeat;
  logic        accept;
  logic        m1_done;
  logic        m2_done;
  logic        store;
  logic        have_next;
  logic [31:0] next_code;
  logic [7:0]  overrun_inc;

  function automatic logic [15:0] show(input logic [7:0] b);
    return {8'h00, b};
  endfunction

  always_comb begin
    is_repeat   = ir_valid && (ir_code == REPEAT_CODE);
    accept      = ir_valid && (ir_code != REPEAT_CODE);
    m1_done     = m1_write && !m1_waitrequest;
    m2_done     = m2_write && !m2_waitrequest;
    store       = accept && (state inside {StWrL, StWrR, StBlankL, StBlankR});
    // A code arriving on the completing edge wins over the older pending one
    have_next   = accept || pend_valid;
    next_code   = accept ? ir_code : pend_code;
    overrun_inc = (overrun_cnt == 8'hFF) ? overrun_cnt : overrun_cnt + 8'd1;
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state         <= StIdle;
      timer         <= '0;
      cur_addr      <= '0;
      pend_valid    <= 1'b0;
      pend_code     <= '0;
      m1_address    <= 2'd0;
      m1_write      <= 1'b0;
      m1_writedata  <= '0;
      m1_byteenable <= 2'b11;
      m2_address    <= 2'd0;
      m2_write      <= 1'b0;
      m2_writedata  <= '0;
      m2_byteenable <= 2'b11;
      busy          <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      if (store) begin
        pend_valid <= 1'b1;
        pend_code  <= ir_code;
        if (pend_valid) overrun_cnt <= overrun_inc;
      end

      unique case (state)
        StIdle: begin
          if (accept) begin
            state        <= StWrL;
            m1_write     <= 1'b1;
            m1_writedata <= show(ir_code[23:16]);
            cur_addr     <= ir_code[7:0];
            busy         <= 1'b1;
          end
        end

        StWrL: begin
          if (m1_done) begin
            state        <= StWrR;
            m1_write     <= 1'b0;
            m2_write     <= 1'b1;
            m2_writedata <= show(cur_addr);
          end
        end

        StWrR, StBlankR: begin
          if (m2_done) begin
            m2_write   <= 1'b0;
            pend_valid <= 1'b0;
            if (have_next) begin
              state        <= StWrL;
              m1_write     <= 1'b1;
              m1_writedata <= show(next_code[23:16]);
              cur_addr     <= next_code[7:0];
            end else if (state == StWrR) begin
              state <= StHold;
              timer <= TimerReload;
              busy  <= 1'b0;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
        end

        StHold: begin
          if (accept) begin
            state        <= StWrL;
            m1_write     <= 1'b1;
            m1_writedata <= show(ir_code[23:16]);
            cur_addr     <= ir_code[7:0];
            busy         <= 1'b1;
          end else if (is_repeat) begin
            timer <= TimerReload;
          end else if (timer == '0) begin
            state        <= StBlankL;
            m1_write     <= 1'b1;
            m1_writedata <= BlankWord;
            busy         <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        StBlankL: begin
          if (m1_done) begin
            state        <= StBlankR;
            m1_write     <= 1'b0;
            m2_write     <= 1'b1;
            m2_writedata <= BlankWord;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_seg_sequencer.sv
// Scoreboard bench for ir_seg_sequencer: expected slave writes are queued when codes
// are driven and checked by a monitor when each write completes.
module tb_ir_seg_sequencer;

  localparam int unsigned HoldCycles = 10;
  localparam logic [31:0] RepeatCode = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_valid = 1'b0;
  logic [31:0] ir_code = '0;
  logic [1:0]  m1_address, m2_address;
  logic        m1_write, m2_write;
  logic [15:0] m1_writedata, m2_writedata;
  logic [1:0]  m1_byteenable, m2_byteenable;
  logic        m1_waitrequest = 1'b0;
  logic        m2_waitrequest = 1'b0;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int vectors = 0;
  int miscompares = 0;
  // bit 16 = port (0 left, 1 right), [15:0] = expected write data
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  ir_seg_sequencer #(
    .HOLD_CYCLES(HoldCycles),
    .REPEAT_CODE(RepeatCode)
  ) dut (
    .csi_clk        (clk),
    .csi_reset      (rst),
    .ir_valid       (ir_valid),
    .ir_code        (ir_code),
    .m1_address     (m1_address),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_waitrequest (m1_waitrequest),
    .m2_address     (m2_address),
    .m2_write       (m2_write),
    .m2_writedata   (m2_writedata),
    .m2_byteenable  (m2_byteenable),
    .m2_waitrequest (m2_waitrequest),
    .busy           (busy),
    .overrun_cnt    (overrun_cnt)
  );

  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst) begin
      if (m1_write || m2_write) begin
        vectors++;
        if (m1_write && m2_write) begin
          miscompares++;
          $display("FAIL both_write: m1_write=%0b m2_write=%0b, required one at a time",
                   m1_write, m2_write);
        end
      end
      if (m1_write && !m1_waitrequest) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL m1_unexpected: got data %h, required no write", m1_writedata);
        end else begin
          e = exp_q.pop_front();
          if ({1'b0, m1_address, m1_byteenable, m1_writedata} !==
              {e[16], 2'b00, 2'b11, e[15:0]}) begin
            miscompares++;
            $display("FAIL m1_write: got port0 addr %h be %b data %h, required port%0d data %h",
                     m1_address, m1_byteenable, m1_writedata, e[16], e[15:0]);
          end
        end
      end
      if (m2_write && !m2_waitrequest) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL m2_unexpected: got data %h, required no write", m2_writedata);
        end else begin
          e = exp_q.pop_front();
          if ({1'b1, m2_address, m2_byteenable, m2_writedata} !==
              {e[16], 2'b00, 2'b11, e[15:0]}) begin
            miscompares++;
            $display("FAIL m2_write: got port1 addr %h be %b data %h, required port%0d data %h",
                     m2_address, m2_byteenable, m2_writedata, e[16], e[15:0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] code);
    ir_valid = 1'b1;
    ir_code  = code;
    step();
    ir_valid = 1'b0;
  endtask

  task automatic expect_code(input logic [31:0] code);
    exp_q.push_back({1'b0, 8'h00, code[23:16]});
    exp_q.push_back({1'b1, 8'h00, code[7:0]});
  endtask

  task automatic expect_blank();
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b1, 16'h0100});
  endtask

  task automatic do_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d writes outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    m1_waitrequest = 1'b0;
    m2_waitrequest = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if ({m1_write, m2_write, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got m1w/m2w/busy %b, required 000", {m1_write, m2_write, busy});
    end
    vectors++;
    if ({m1_address, m1_writedata, m2_address, m2_writedata} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h %h %h %h, required all zero",
               m1_address, m1_writedata, m2_address, m2_writedata);
    end
    vectors++;
    if ({m1_byteenable, m2_byteenable, overrun_cnt} !== {4'b1111, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_be_ovr: got be %b %b ovr %0d, required 11 11 0",
               m1_byteenable, m2_byteenable, overrun_cnt);
    end
  endtask

  task automatic test_basic();
    int busy_n = 0;
    expect_code(32'h00FF_1A2B);
    pulse(32'h00FF_1A2B);
    vectors++;
    if ({m1_write, m1_writedata} !== {1'b1, 16'h00FF}) begin
      miscompares++;
      $display("FAIL basic_latency: got m1_write %b data %h, required 1 00ff",
               m1_write, m1_writedata);
    end
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_n++;
      step();
    end
    vectors++;
    if (busy_n != 2) begin
      miscompares++;
      $display("FAIL basic_busy: got %0d busy cycles, required 2", busy_n);
    end
    do_reset();
  endtask

  task automatic test_stall();
    m1_waitrequest = 1'b1;
    expect_code(32'h0012_3456);
    pulse(32'h0012_3456);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({m1_write, m2_write, m1_address, m1_writedata} !== {1'b1, 1'b0, 2'd0, 16'h0012}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got m1w %b m2w %b addr %h data %h, required 1 0 0 0012",
                 i, m1_write, m2_write, m1_address, m1_writedata);
      end
      if (i < 5) step();
    end
    m1_waitrequest = 1'b0;
    step();
    vectors++;
    if ({m1_write, m2_write, m2_writedata} !== {1'b0, 1'b1, 16'h0056}) begin
      miscompares++;
      $display("FAIL stall_m2: got m1w %b m2w %b data %h, required 0 1 0056",
               m1_write, m2_write, m2_writedata);
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done: got busy %b, required 0", busy);
    end
    do_reset();
  endtask

  task automatic test_hold();
    int n;
    expect_code(32'h0033_0044);
    expect_blank();
    pulse(32'h0033_0044);
    step();
    step();
    n = 0;
    while (n < 40 && !m1_write) begin
      step();
      n++;
    end
    vectors++;
    if (n != HoldCycles) begin
      miscompares++;
      $display("FAIL hold_len: got %0d hold cycles, required %0d", n, HoldCycles);
    end
    step();
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_blank_done: got busy %b, required 0", busy);
    end
    repeat (15) step();
    vectors++;
    if ({m1_write, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL hold_idle: got m1w/busy %b, required 00", {m1_write, busy});
    end

    expect_code(32'h0055_0066);
    expect_blank();
    pulse(32'h0055_0066);
    step();
    step();
    n = 0;
    repeat (8) begin
      step();
      n++;
    end
    pulse(RepeatCode);
    n++;
    while (n < 60 && !m1_write) begin
      step();
      n++;
    end
    vectors++;
    if (n != HoldCycles + 9) begin
      miscompares++;
      $display("FAIL hold_repeat: got %0d hold cycles, required %0d", n, HoldCycles + 9);
    end
    step();
    step();
    pulse(RepeatCode);
    vectors++;
    if ({m1_write, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL repeat_idle: got m1w/busy %b, required 00", {m1_write, busy});
    end
    do_reset();
  endtask

  task automatic test_overrun();
    int n;
    m1_waitrequest = 1'b1;
    expect_code(32'h00A1_00B1);
    expect_code(32'h00A3_00B3);
    pulse(32'h00A1_00B1);
    pulse(32'h00A2_00B2);
    pulse(32'h00A3_00B3);
    vectors++;
    if (overrun_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL overrun_cnt: got %0d, required 1", overrun_cnt);
    end
    m1_waitrequest = 1'b0;
    n = 0;
    while (n < 20 && busy) begin
      step();
      n++;
    end
    vectors++;
    if (busy !== 1'b0 || overrun_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL overrun_drain: got busy %b ovr %0d, required 0 1", busy, overrun_cnt);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    expect_code(32'h0011_0022);
    expect_code(32'h0077_0088);
    pulse(32'h0011_0022);
    step();
    pulse(32'h0077_0088);
    vectors++;
    if ({m1_write, busy, m1_writedata} !== {2'b11, 16'h0077}) begin
      miscompares++;
      $display("FAIL b2b_next: got m1w %b busy %b data %h, required 1 1 0077",
               m1_write, busy, m1_writedata);
    end
    step();
    vectors++;
    if ({m2_write, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_m2: got m2w %b busy %b, required 1 1", m2_write, busy);
    end
    step();
    vectors++;
    if ({busy, overrun_cnt} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL b2b_done: got busy %b ovr %0d, required 0 0", busy, overrun_cnt);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    m2_waitrequest = 1'b1;
    expect_code(32'h00C1_00D1);
    pulse(32'h00C1_00D1);
    step();
    pulse(32'h00C2_00D2);
    pulse(32'h00C3_00D3);
    vectors++;
    if ({m2_write, overrun_cnt} !== {1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL rmid_pre: got m2w %b ovr %0d, required 1 1", m2_write, overrun_cnt);
    end
    // The stalled right-hand write is aborted by reset and never completes
    void'(exp_q.pop_back());
    rst = 1'b1;
    step();
    vectors++;
    if ({m1_write, m2_write, busy, overrun_cnt, m1_writedata, m2_writedata} !== 43'd0) begin
      miscompares++;
      $display("FAIL rmid_reset: got m1w %b m2w %b busy %b ovr %0d d1 %h d2 %h, required zeros",
               m1_write, m2_write, busy, overrun_cnt, m1_writedata, m2_writedata);
    end
    rst = 1'b0;
    m2_waitrequest = 1'b0;
    expect_code(32'h00E1_00F1);
    pulse(32'h00E1_00F1);
    vectors++;
    if ({m1_write, m1_writedata} !== {1'b1, 16'h00E1}) begin
      miscompares++;
      $display("FAIL rmid_fresh: got m1w %b data %h, required 1 00e1", m1_write, m1_writedata);
    end
    step();
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_no_pending: got busy %b, required 0", busy);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hold();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
